echo_feedback: RTL and testbench

Parametrised successor to the team's single-tap echo. It is a mono feedback delay line with a circular sample buffer and run-time delay length, feedback gain and wet level. Output is saturated, with overrun detection and a self-clearing buffer after reset. It sits between `i2s_rx` and `i2s_tx` in the instrument top level, clocked by `bclk` and fed the codec `lrclk` as its sample strobe.

---
 rtl/echo_feedback_if.sv | 27 ++
 rtl/echo_feedback.sv | 158 +++++++++++++++
 tb/tb_echo_feedback.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/echo_feedback_if.sv
// Sample-side bus of the echo block: strobe, run-time controls, audio in/out and status.
// The controller (i2s glue or a bench) uses master; the echo core uses slave.
interface echo_feedback_if #(
  parameter int BITSIZE  = 16,
  parameter int ADDRSIZE = 12,
  parameter int GAINSIZE = 8
);
  logic                       lrclk;
  logic                       enable;
  logic        [ADDRSIZE-1:0] delay;
  logic        [GAINSIZE-1:0] feedback;
  logic        [GAINSIZE-1:0] mix;
  logic signed [BITSIZE-1:0]  in;
  logic signed [BITSIZE-1:0]  out;
  logic                       busy;
  logic                       overrun;

  modport master (
    output lrclk, enable, delay, feedback, mix, in,
    input  out, busy, overrun
  );

  modport slave (
    input  lrclk, enable, delay, feedback, mix, in,
    output out, busy, overrun
  );
endinterface

// File: rtl/echo_feedback.sv
// Mono feedback delay line: circular sample buffer, run-time delay/feedback/wet gain,
// saturating arithmetic, sticky overrun flag and a zero-fill pass after every reset.
module echo_feedback #(
  parameter int BITSIZE  = 16,
  parameter int ADDRSIZE = 12,
  parameter int GAINSIZE = 8
) (
  input  logic             bclk,
  input  logic             reset,
  echo_feedback_if.slave   bus,
  output logic [2:0]       dbg_state
);

  // Handshake: a rising edge of lrclk is the "valid" for one sample; the block is
  // "ready" only while busy is low (IDLE). An edge seen while processing is not
  // stalled but dropped and recorded in overrun; edges during CLEAR are ignored.

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = BITSIZE + GAINSIZE + 1;

  localparam logic [ADDRSIZE-1:0]       CADDR_LAST = '1;
  localparam logic signed [BITSIZE-1:0] SMAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0] SMIN = {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CALC  = 3'd4,
    ST_WRITE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                       lrclk_q;
  logic                       strobe;
  logic        [ADDRSIZE-1:0] caddr;
  logic        [ADDRSIZE-1:0] wptr;
  logic        [ADDRSIZE-1:0] raddr;

  logic signed [BITSIZE-1:0]  x;
  logic        [ADDRSIZE-1:0] dl;
  logic        [GAINSIZE-1:0] fb;
  logic        [GAINSIZE-1:0] mx;
  logic                       en;

  logic        [BITSIZE-1:0]  rdata;
  logic signed [BITSIZE-1:0]  d;
  logic signed [BITSIZE-1:0]  w_r;
  logic signed [BITSIZE-1:0]  y_r;
  logic signed [BITSIZE-1:0]  out_r;
  logic                       overrun_r;

  logic signed [PW-1:0]       d_ext, fb_ext, mx_ext, p_fb, p_mx;
  logic signed [BITSIZE:0]    s_fb, s_mx, sum_fb, sum_mx;
  logic signed [BITSIZE-1:0]  w_c, y_c;

  logic                       mem_we;
  logic        [ADDRSIZE-1:0] mem_waddr;
  logic        [BITSIZE-1:0]  mem_wdata;
  logic        [BITSIZE-1:0]  mem [DEPTH];

  function automatic logic signed [BITSIZE-1:0] sat(input logic signed [BITSIZE:0] v);
    if (v[BITSIZE] != v[BITSIZE-1]) return v[BITSIZE] ? SMIN : SMAX;
    return v[BITSIZE-1:0];
  endfunction

  assign strobe = bus.lrclk & ~lrclk_q;
  // dl = 0 wraps to wptr itself, i.e. the oldest sample (full buffer delay).
  assign raddr  = wptr - dl;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CLEAR: if (caddr == CADDR_LAST) state_nxt = ST_IDLE;
      ST_IDLE:  if (strobe) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Gains are unsigned Q0.GAINSIZE; zero-extend so the product stays signed.
  always_comb begin
    d_ext  = PW'(d);
    fb_ext = PW'(fb);
    mx_ext = PW'(mx);
    p_fb   = d_ext * fb_ext;
    p_mx   = d_ext * mx_ext;
    s_fb   = (BITSIZE+1)'(p_fb >>> GAINSIZE);
    s_mx   = (BITSIZE+1)'(p_mx >>> GAINSIZE);
    sum_fb = {x[BITSIZE-1], x} + s_fb;
    sum_mx = {x[BITSIZE-1], x} + s_mx;
    w_c    = en ? sat(sum_fb) : x;
    y_c    = en ? sat(sum_mx) : x;
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      lrclk_q   <= 1'b0;
      caddr     <= '0;
      wptr      <= '0;
      x         <= '0;
      dl        <= '0;
      fb        <= '0;
      mx        <= '0;
      en        <= 1'b0;
      d         <= '0;
      w_r       <= '0;
      y_r       <= '0;
      out_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      lrclk_q <= bus.lrclk;
      if (state == ST_CLEAR) caddr <= caddr + ADDRSIZE'(1);
      if (state == ST_IDLE && strobe) begin
        x  <= bus.in;
        dl <= bus.delay;
        fb <= bus.feedback;
        mx <= bus.mix;
        en <= bus.enable;
      end
      if (strobe && state != ST_IDLE && state != ST_CLEAR) overrun_r <= 1'b1;
      if (state == ST_WAIT) d <= rdata;
      if (state == ST_CALC) begin
        w_r <= w_c;
        y_r <= y_c;
      end
      if (state == ST_WRITE) begin
        out_r <= y_r;
        wptr  <= wptr + ADDRSIZE'(1);
      end
    end
  end

  // The buffer shares one write port between the zero-fill pass and sample writes.
  always_comb begin
    mem_we    = (state == ST_CLEAR) || (state == ST_WRITE);
    mem_waddr = (state == ST_CLEAR) ? caddr : wptr;
    mem_wdata = (state == ST_CLEAR) ? '0 : w_r;
  end

  always_ff @(posedge bclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rdata <= mem[raddr];
  end

  assign bus.out     = out_r;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.overrun = overrun_r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_echo_feedback.sv
// Directed bench for echo_feedback (ADDRSIZE=4): expected outputs are queued at strobe
// time and a monitor compares them, with latency, when the DUT leaves WRITE.
module tb_echo_feedback;
  localparam int BS = 16;
  localparam int AS = 4;
  localparam int GS = 8;
  localparam logic [2:0] ST_WRITE = 3'd5;

  logic       bclk  = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  echo_feedback_if #(.BITSIZE(BS), .ADDRSIZE(AS), .GAINSIZE(GS)) efi ();

  echo_feedback #(.BITSIZE(BS), .ADDRSIZE(AS), .GAINSIZE(GS)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .bus       (efi),
    .dbg_state (dbg_state)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [BS-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one negedge after a WRITE cycle the new out value is presented.
  logic [2:0]    prev_st = 3'd0;
  logic [BS-1:0] mon_e;
  int            mon_c;
  always @(negedge bclk) begin
    if (prev_st == ST_WRITE) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got %0d expected no output", efi.out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("out", efi.out, $signed(mon_e));
        check("out_latency", cyc, mon_c);
      end
    end
    prev_st = dbg_state;
  end

  // All driver tasks start and end 1ns after a rising edge.
  task automatic sample(input logic signed [BS-1:0] xin, input logic [AS-1:0] dl,
                        input logic [GS-1:0] fb, input logic [GS-1:0] mx,
                        input logic en, input logic signed [BS-1:0] exp);
    efi.in       = xin;
    efi.delay    = dl;
    efi.feedback = fb;
    efi.mix      = mx;
    efi.enable   = en;
    efi.lrclk    = 1'b1;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 5);
    @(posedge bclk); #1;
    efi.lrclk    = 1'b0;
    // Controls only matter at the strobe edge; scramble them afterwards.
    efi.in       = BS'($urandom);
    efi.delay    = AS'($urandom);
    efi.feedback = GS'($urandom);
    efi.mix      = GS'($urandom);
    efi.enable   = 1'($urandom_range(0, 1));
    repeat (7) @(posedge bclk);
    #1;
  endtask

  task automatic reset_and_clear(input bit strobe_in_clear);
    int cnt;
    reset = 1'b1;
    #1;
    check("rst_out", efi.out, 0);
    check("rst_busy", efi.busy, 1);
    check("rst_overrun", efi.overrun, 0);
    repeat (3) @(posedge bclk);
    #1;
    reset = 1'b0;
    cnt   = 0;
    while (efi.busy && cnt < 100) begin
      efi.lrclk = strobe_in_clear && (cnt == 5);
      @(posedge bclk); #1;
      cnt++;
    end
    efi.lrclk = 1'b0;
    check("clear_cycles", cnt, 16);
    check("clear_overrun", efi.overrun, 0);
    repeat (2) @(posedge bclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    efi.lrclk    = 1'b0;
    efi.enable   = 1'b1;
    efi.delay    = '0;
    efi.feedback = '0;
    efi.mix      = '0;
    efi.in       = '0;

    // Reset/clear with a strobe during clear; first sample reads the zeroed buffer.
    reset_and_clear(1'b1);
    sample(16'sd1000, 4'd0, 8'd0, 8'd255, 1'b1, 16'sd1000);

    // Impulse, delay 10, mix 1/2.
    reset_and_clear(1'b0);
    for (int k = 0; k < 13; k++) begin
      sample((k == 0) ? 16'sd16384 : 16'sd0, 4'd10, 8'd0, 8'd128, 1'b1,
             (k == 0) ? 16'sd16384 : (k == 10) ? 16'sd8192 : 16'sd0);
    end

    // Feedback decay, delay 4, fb 1/2, mix 255/256.
    reset_and_clear(1'b0);
    for (int k = 0; k < 9; k++) begin
      sample((k == 0) ? 16'sd16384 : 16'sd0, 4'd4, 8'd128, 8'd255, 1'b1,
             (k == 0) ? 16'sd16384 : (k == 4) ? 16'sd16320 :
             (k == 8) ? 16'sd8160 : 16'sd0);
    end
    check("mem4", $signed(dut.mem[4]), 8192);
    check("mem8", $signed(dut.mem[8]), 4096);

    // Saturation, delay 1, fb and mix 255/256.
    reset_and_clear(1'b0);
    for (int k = 0; k < 6; k++) sample(16'sd32767, 4'd1, 8'd255, 8'd255, 1'b1, 16'sd32767);
    sample(-16'sd32768, 4'd1, 8'd255, 8'd255, 1'b1, -16'sd129);
    for (int k = 0; k < 5; k++) sample(-16'sd32768, 4'd1, 8'd255, 8'd255, 1'b1, -16'sd32768);

    // Overrun: second edge 3 cycles after the first lands in CALC and is dropped.
    reset_and_clear(1'b0);
    efi.in = 16'sd500; efi.delay = 4'd5; efi.feedback = 8'd0; efi.mix = 8'd0;
    efi.enable = 1'b1; efi.lrclk = 1'b1;
    exp_q.push_back(16'sd500);
    exp_cyc_q.push_back(cyc + 5);
    @(posedge bclk); #1; efi.lrclk = 1'b0;
    @(posedge bclk); #1;
    @(posedge bclk); #1; efi.lrclk = 1'b1;
    @(posedge bclk); #1; efi.lrclk = 1'b0;
    check("overrun_set", efi.overrun, 1);
    repeat (6) @(posedge bclk);
    #1;
    sample(-16'sd1234, 4'd2, 8'd0, 8'd0, 1'b1, -16'sd1234);
    check("overrun_sticky", efi.overrun, 1);

    // Async reset while in WAIT abandons the sample; nothing is queued for it.
    efi.in = 16'sd777; efi.delay = 4'd3; efi.enable = 1'b1; efi.lrclk = 1'b1;
    @(posedge bclk); #1; efi.lrclk = 1'b0;
    @(posedge bclk); #2;
    check("wait_state", dbg_state, 3);
    reset = 1'b1;
    #1;
    check("midop_out", efi.out, 0);
    check("midop_busy", efi.busy, 1);
    reset_and_clear(1'b0);

    // Bypass with a ramp, then full-depth echo (delay 0) across the wptr wrap.
    for (int k = 0; k < 16; k++) begin
      sample(BS'(1024 * (k + 1)), 4'd7, 8'd200, 8'd255, 1'b0, BS'(1024 * (k + 1)));
    end
    for (int m = 1; m <= 5; m++) begin
      sample(16'sd0, 4'd0, 8'd0, 8'd255, 1'b1, BS'(1020 * m));
    end

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 50) begin
      @(posedge bclk); #1;
      waitc++;
    end
    check("pending_outputs", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
